// File: rtl/memory_seq_pkg.sv
// rtl/memory_seq_pkg.sv - shared state, record types and width helper for the memory request sequencer
package memory_seq_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                      write;
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      error;
  } rsp_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/memory_req_fifo.sv
// rtl/memory_req_fifo.sv - synchronous command FIFO with occupancy count
module memory_req_fifo
  import memory_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_req_sequencer.sv
// rtl/memory_req_sequencer.sv - queues read/write commands and issues them one at a time to the memory host
module memory_req_sequencer
  import memory_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 6,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_read_valid,
  input  logic                  mem_write_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = count_width(FIFO_DEPTH);
  localparam int TMR_W = count_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  seq_state_t            state, state_n;
  logic [CMD_W-1:0]      head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push;
  logic                  pop;
  logic                  done;
  logic                  cur_write, cur_write_n;
  logic [TMR_W-1:0]      timer, timer_n;
  logic [ADDR_WIDTH-1:0] address_n;
  logic [DATA_WIDTH-1:0] write_data_n;
  logic                  write_enable_n;
  logic                  read_enable_n;
  logic                  rsp_valid_n;
  logic                  rsp_write_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n;
  logic                  rsp_error_n;
  logic [7:0]            err_count_n;

  assign cmd_ready = rst_n & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE) | (fifo_count != '0);
  assign done      = cur_write ? mem_write_ack : mem_read_valid;

  memory_req_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({cmd_write, cmd_addr, cmd_wdata}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_n        = state;
    pop            = 1'b0;
    cur_write_n    = cur_write;
    timer_n        = timer;
    address_n      = mem_address;
    write_data_n   = mem_write_data;
    write_enable_n = mem_write_enable;
    read_enable_n  = mem_read_enable;
    rsp_valid_n    = rsp_valid;
    rsp_write_n    = rsp_write;
    rsp_rdata_n    = rsp_rdata;
    rsp_error_n    = rsp_error;
    err_count_n    = err_count;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          cur_write_n    = head[CMD_W-1];
          address_n      = head[DATA_WIDTH +: ADDR_WIDTH];
          write_data_n   = head[DATA_WIDTH-1:0];
          write_enable_n = head[CMD_W-1];
          read_enable_n  = ~head[CMD_W-1];
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        write_enable_n = 1'b0;
        read_enable_n  = 1'b0;
        timer_n        = '0;
        state_n        = WAIT;
      end
      WAIT: begin
        if (done) begin
          rsp_valid_n = 1'b1;
          rsp_write_n = cur_write;
          rsp_rdata_n = cur_write ? '0 : mem_read_data;
          rsp_error_n = 1'b0;
          state_n     = RESP;
        end else if (timer == TMR_LAST) begin
          rsp_valid_n = 1'b1;
          rsp_write_n = cur_write;
          rsp_rdata_n = '0;
          rsp_error_n = 1'b1;
          if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
          state_n     = RESP;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      RESP: begin
        // Returning to IDLE here means the next pop is at least one cycle later.
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cur_write        <= 1'b0;
      timer            <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_write        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_error        <= 1'b0;
      err_count        <= '0;
    end else begin
      state            <= state_n;
      cur_write        <= cur_write_n;
      timer            <= timer_n;
      mem_address      <= address_n;
      mem_write_data   <= write_data_n;
      mem_write_enable <= write_enable_n;
      mem_read_enable  <= read_enable_n;
      rsp_valid        <= rsp_valid_n;
      rsp_write        <= rsp_write_n;
      rsp_rdata        <= rsp_rdata_n;
      rsp_error        <= rsp_error_n;
      err_count        <= err_count_n;
    end
  end

endmodule

// File: doc/memory_req_sequencer.md
Name: memory_req_sequencer

Overview:
Upstream command stage for the memory host. Accepts read/write commands on a valid/ready interface and buffers them in a small FIFO. Issues one command at a time as a single-cycle enable pulse, waits for write_ack/read_valid (with timeout), and returns one response per command on a valid/ready response channel. Sits between a traffic source/testbench driver and the memory host's address/write_data/write_enable/read_enable port set.

Parameters:
DATA_WIDTH, 16, memory data width (matches host)
ADDR_WIDTH, 6, memory address width (matches host)
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 15, WAIT-state cycles without completion before error response; >=2

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  command address
cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
mem_address  output  ADDR_WIDTH  to host address
mem_write_data  output  DATA_WIDTH  to host write_data
mem_write_enable  output  1  to host write_enable, 1-cycle pulse
mem_read_enable  output  1  to host read_enable, 1-cycle pulse
mem_read_data  input  DATA_WIDTH  from host read_data
mem_read_valid  input  1  from host read_valid
mem_write_ack  input  1  from host write_ack
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when valid&ready
rsp_write  output  1  response belongs to a write
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
rsp_error  output  1  1=timeout
busy  output  1  state!=IDLE or FIFO non-empty
err_count  output  8  timeout count, saturating at 255

Behaviour:
- Reset (rst_n low, async): FIFO flushed, state=IDLE, all registered outputs 0, err_count=0. cmd_ready is forced 0 while rst_n is low. Reset mid-operation drops the in-flight command, any pending response and enables immediately.
- cmd_ready = rst_n & (count < FIFO_DEPTH). It depends only on count; a pop in the same cycle does not open a slot.
- FIFO push on cmd_valid&cmd_ready stores {write, addr, wdata}. Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- FSM states IDLE, ISSUE, WAIT, RESP. All mem_* and rsp_* outputs are registered.
- IDLE: if FIFO non-empty, pop head, load mem_address/mem_write_data, set the matching enable to 1, go to ISSUE. Otherwise stay.
- ISSUE: lasts exactly one cycle with the enable high. At the next edge clear both enables, clear timer to 0, go to WAIT.
- WAIT: completion is (write & mem_write_ack) or (read & mem_read_valid).
  - On completion: rsp_valid=1, rsp_write=type, rsp_rdata=mem_read_data for reads and 0 for writes, rsp_error=0, go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1: rsp_valid=1, rsp_error=1, rsp_rdata=0, err_count+1 (saturating), go to RESP.
  - Else timer+1.
- mem_write_ack/mem_read_valid outside WAIT, or of the wrong type in WAIT, are ignored.
- RESP: hold all rsp_* stable until rsp_ready. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE. No new issue occurs in the handshake cycle.
- Latency, empty idle FIFO: command accepted at edge E0; enable high after E1; host ack registered at E2; rsp_valid high after E3. Minimum issue spacing is 4 cycles with rsp_ready held 1.
- Strict in-order, single outstanding command. Enables are never both high.

Decomposition:
- Package memory_seq_pkg: state enum (IDLE, ISSUE, WAIT, RESP), command record type {write, addr, wdata}, response record type, and a clog2-based timer/count width function.
- One sub-module: memory_req_fifo. Parameterised synchronous FIFO with push/pop/full/empty/count, async active-low reset; instantiated once for the command queue.

Test Plan:
- Reset then write addr 0x05 data 0xBEEF, rsp_ready=1 -> mem_write_enable high exactly 1 cycle with mem_address=0x05, mem_write_data=0xBEEF; rsp_valid 3 cycles after acceptance, rsp_write=1, rsp_error=0, rsp_rdata=0.
- Read addr 0x05 with host model returning 0xBEEF -> mem_read_enable 1-cycle pulse; rsp_rdata=0xBEEF, rsp_write=0, rsp_error=0.
- Hold rsp_ready=0 and push 6 commands back-to-back -> first command issued; cmd_ready drops after the FIFO holds 4 entries; no second issue until the response handshakes; all 6 responses arrive in order.
- Host never acks a read -> rsp_error=1 and rsp_rdata=0 exactly TIMEOUT_CYCLES (15) WAIT cycles after issue; err_count=1. Repeat 300 times -> err_count=255, saturated.
- Spurious mem_write_ack pulses while in IDLE and during a read's WAIT -> ignored; the read completes only on mem_read_valid.
- Assert rst_n=0 during WAIT with 3 commands queued -> enables, rsp_valid and busy go 0 immediately; cmd_ready=0 during reset and 1 after release; no stale response appears afterwards.
